uart_tx_framer: RTL and testbench

- UART transmitter for the UART block; the transmit direction paired with the RX datapath.
- Clocked at the baud clock (one clk period = one bit time); produces an idle-high serial line.
- Frame: start (0), DATA_WIDTH data bits LSB first, optional parity, stop (1).
- Has a one-entry holding register, so the next byte is accepted during a frame and frames go back-to-back with no idle bit.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_serializer.sv | 51 +++++
 rtl/uart_tx_framer.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit framer: FSM state encoding, parity
// selection and line levels.
package uart_tx_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register (LSB out first) plus data-bit counter for the UART
// transmitter; ser_done flags the last data bit of the frame.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    input  logic                  cnt_en,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign ser_bit  = shift_q[0];
    assign ser_done = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    // Counter wraps to zero on the last data bit so it is clear on exit.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_data;
            cnt_d   = '0;
        end else begin
            if (shift_en) begin
                shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            end
            if (cnt_en) begin
                cnt_d = ser_done ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter clocked at the baud rate, with a one-entry holding register
// for back-to-back frames. Define UART_TX_STOP2_EN for two stop bits.
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  ready,
    output logic                  tx_out,
    output logic                  busy
);

    logic [2:0]            state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_pen_q, hold_pen_d;
    logic                  hold_pbit_q, hold_pbit_d;
    logic                  pen_q, pen_d;
    logic                  pbit_q, pbit_d;
`ifdef UART_TX_STOP2_EN
    logic                  stop_cnt_q, stop_cnt_d;
`endif

    logic                  accept;
    logic                  in_pbit;
    logic                  direct_load;
    logic                  stop_last;
    logic                  ser_load;
    logic [DATA_WIDTH-1:0] ser_load_data;
    logic                  shift_en;
    logic                  cnt_en;
    logic                  ser_bit;
    logic                  ser_done;

    assign accept  = data_valid && ready_q;
    assign in_pbit = (par_typ == PAR_EVEN) ? (^p_data) : ~(^p_data);

    assign ready  = ready_q;
    assign tx_out = tx_q;
    assign busy   = busy_q;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst),
        .load      (ser_load),
        .load_data (ser_load_data),
        .shift_en  (shift_en),
        .cnt_en    (cnt_en),
        .ser_bit   (ser_bit),
        .ser_done  (ser_done)
    );

    // tx_d is the line level for the state being entered, so tx_out is a flop.
    always_comb begin
        state_d       = state_q;
        tx_d          = STOP_BIT;
        hold_full_d   = hold_full_q;
        hold_data_d   = hold_data_q;
        hold_pen_d    = hold_pen_q;
        hold_pbit_d   = hold_pbit_q;
        pen_d         = pen_q;
        pbit_d        = pbit_q;
        ser_load      = 1'b0;
        ser_load_data = p_data;
        shift_en      = 1'b0;
        cnt_en        = 1'b0;
        direct_load   = 1'b0;
        stop_last     = 1'b0;
`ifdef UART_TX_STOP2_EN
        stop_cnt_d    = stop_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    direct_load = 1'b1;
                    state_d     = START;
                    tx_d        = START_BIT;
                end
            end
            START: begin
                state_d  = DATA;
                tx_d     = ser_bit;
                shift_en = 1'b1;
            end
            DATA: begin
                cnt_en = 1'b1;
                if (!ser_done) begin
                    tx_d     = ser_bit;
                    shift_en = 1'b1;
                end else if (pen_q) begin
                    state_d = PARITY;
                    tx_d    = pbit_q;
                end else begin
                    state_d = STOP;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
`ifdef UART_TX_STOP2_EN
                if (!stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    stop_cnt_d = 1'b0;
                    stop_last  = 1'b1;
                end
`else
                stop_last = 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of frame: a held byte takes priority over a fresh accept.
        if (stop_last) begin
            if (hold_full_q) begin
                ser_load      = 1'b1;
                ser_load_data = hold_data_q;
                pen_d         = hold_pen_q;
                pbit_d        = hold_pbit_q;
                hold_full_d   = 1'b0;
                state_d       = START;
                tx_d          = START_BIT;
            end else if (accept) begin
                direct_load = 1'b1;
                state_d     = START;
                tx_d        = START_BIT;
            end else begin
                state_d = IDLE;
            end
        end

        if (direct_load) begin
            ser_load      = 1'b1;
            ser_load_data = p_data;
            pen_d         = par_en;
            pbit_d        = in_pbit;
        end else if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = p_data;
            hold_pen_d  = par_en;
            hold_pbit_d = in_pbit;
        end
    end

    assign busy_d  = (state_d != IDLE);
    assign ready_d = !hold_full_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tx_q        <= STOP_BIT;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_pen_q  <= 1'b0;
            hold_pbit_q <= 1'b0;
            pen_q       <= 1'b0;
            pbit_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_pen_q  <= hold_pen_d;
            hold_pbit_q <= hold_pbit_d;
            pen_q       <= pen_d;
            pbit_q      <= pbit_d;
        end
    end

`ifdef UART_TX_STOP2_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= stop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer; follows UART_TX_STOP2_EN
// when it is defined for the build.
module tb_uart_tx_framer;

`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       ready;
    logic       tx_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ready      (ready),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Start bit, LSB-first data, optional parity, then stop bit(s) as 1s.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic pe, input logic pb);
        logic [11:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (pe) b[9] = pb;
        return b;
    endfunction

    task automatic offer(input logic [7:0] d, input logic pe, input logic pt);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
    endtask

    // Garbage on the inputs after capture must not disturb the frame in flight.
    task automatic release_inputs();
        data_valid = 1'b0;
        p_data     = 8'h01;
        par_en     = ~par_en;
        par_typ    = ~par_typ;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_tx%0d", tag, i), tx_out, 1'b1);
            chk($sformatf("%s_busy%0d", tag, i), busy, 1'b0);
            chk($sformatf("%s_ready%0d", tag, i), ready, 1'b1);
            release_inputs();
        end
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                                input logic pb, input int rdy_drop, input int off_at,
                                input logic [15:0] off_bytes, input int off_cnt);
        logic [11:0] bits;
        int          n;
        bits = frame_bits(d, pe, pb);
        n    = 10 + int'(pe) + NSTOP - 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_tx%0d", tag, i), tx_out, bits[i]);
            chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            chk($sformatf("%s_ready%0d", tag, i), ready, (i < rdy_drop));
            if (off_cnt > 0 && i >= off_at && i < off_at + off_cnt)
                offer(off_bytes[8*(i-off_at) +: 8], 1'b0, 1'b0);
            else
                release_inputs();
        end
    endtask

    initial begin
        logic [11:0] rb;
        rst        = 1'b0;
        data_valid = 1'b0;
        p_data     = 8'h00;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", tx_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b1);
        rst = 1'b1;

        idle_check("idle", 5);

        // 0xA5 even parity (4 ones -> 0), then odd parity (-> 1)
        offer(8'hA5, 1'b1, 1'b0);
        expect_frame("a5e", 8'hA5, 1'b1, 1'b0, 99, -1, 16'h0000, 0);
        idle_check("a5e_end", 1);
        offer(8'hA5, 1'b1, 1'b1);
        expect_frame("a5o", 8'hA5, 1'b1, 1'b1, 99, -1, 16'h0000, 0);
        idle_check("a5o_end", 1);

        // 0x00 without parity: busy falls right after the stop bit
        offer(8'h00, 1'b0, 1'b0);
        expect_frame("z", 8'h00, 1'b0, 1'b0, 99, -1, 16'h0000, 0);
        idle_check("z_end", 1);

        // Back-to-back: 0x0F offered while data bit 2 of 0x55 is on the line
        offer(8'h55, 1'b0, 1'b0);
        expect_frame("b1", 8'h55, 1'b0, 1'b0, 4, 3, 16'h000F, 1);
        expect_frame("b2", 8'h0F, 1'b0, 1'b0, 99, -1, 16'h0000, 0);
        idle_check("b_end", 1);

        // Overrun: 0x11, 0x22, 0x33 on consecutive cycles; 0x33 is dropped
        offer(8'h11, 1'b0, 1'b0);
        expect_frame("o1", 8'h11, 1'b0, 1'b0, 1, 0, 16'h3322, 2);
        expect_frame("o2", 8'h22, 1'b0, 1'b0, 99, -1, 16'h0000, 0);
        idle_check("o_end", 3);

        // Reset during data bit 3 of 0x53 (bit3 = 0) with 0x99 held
        offer(8'h53, 1'b0, 1'b0);
        rb = frame_bits(8'h53, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("r_tx%0d", i), tx_out, rb[i]);
            if (i == 1) offer(8'h99, 1'b0, 1'b0);
            else release_inputs();
        end
        chk("r_ready_held", ready, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("r_async_tx", tx_out, 1'b1);
        chk("r_async_busy", busy, 1'b0);
        chk("r_async_ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        idle_check("r_idle", 3);

        // 0xC3 odd parity (4 ones -> 1) after reset
        offer(8'hC3, 1'b1, 1'b1);
        expect_frame("c3", 8'hC3, 1'b1, 1'b1, 99, -1, 16'h0000, 0);
        idle_check("c3_end", 1);

        // 0xFF without parity; ends in NSTOP stop bits
        offer(8'hFF, 1'b0, 1'b0);
        expect_frame("ff", 8'hFF, 1'b0, 1'b0, 99, -1, 16'h0000, 0);
        idle_check("ff_end", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
